fpadd_arbiter: RTL and testbench

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

---
 rtl/fpadd_arbiter_pkg.sv | 17 +
 rtl/fpadd_arbiter_adder.sv | 108 ++++++++++
 rtl/fpadd_arbiter.sv | 137 +++++++++++++
 tb/tb_fpadd_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_arbiter_pkg.sv
// Shared definitions for the FP32 adder arbiter.
//   FP_W        : FP32 word width (32)
//   DEFAULT_LAT : default issue-to-result latency of the shared adder
//   OWNER_W     : width of the requester index carried in a tag (up to 8 requesters)
//   tag_t       : {valid, owner} record travelling alongside an operation
package fpadd_arbiter_pkg;

    localparam int FP_W        = 32;
    localparam int DEFAULT_LAT = 3;
    localparam int OWNER_W     = 3;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } tag_t;

endpackage

// File: rtl/fpadd_arbiter_adder.sv
// fpadd_pipelined: FP32 adder with a fixed LAT-cycle latency.
// The sum is formed from reg_A/reg_B in the issue cycle, registered, and then
// carried through LAT-1 further stages so that out shows it exactly LAT cycles
// after the operands were presented.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears all stages)
//   reg_A/reg_B: FP32 operands (in)
//   out        : FP32 sum (out)
// Arithmetic: round-to-nearest-even; subnormal inputs and results flush to zero;
// NaN inputs propagate as quiet NaN; inf + -inf gives the default quiet NaN.
module fpadd_pipelined
    import fpadd_arbiter_pkg::*;
#(
    parameter int LAT = DEFAULT_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [FP_W-1:0] reg_A,
    input  logic [FP_W-1:0] reg_B,
    output logic [FP_W-1:0] out
);

    function automatic logic [FP_W-1:0] fp32_add(input logic [FP_W-1:0] a,
                                                 input logic [FP_W-1:0] b);
        logic [31:0] x, y, res;
        logic [7:0]  ex, ey, d;
        logic [26:0] mx, my, my0;
        logic [27:0] s;
        logic [24:0] rm;
        logic        sticky, rnd;
        int          e, lz;
        res = '0; mx = '0; my = '0; my0 = '0; s = '0; rm = '0;
        d = '0; sticky = 1'b0; rnd = 1'b0; e = 0; lz = 0;
        // x always holds the operand of larger magnitude; the result takes its sign
        if (b[30:0] > a[30:0]) begin
            x = b; y = a;
        end else begin
            x = a; y = b;
        end
        ex = x[30:23];
        ey = y[30:23];
        if (ex == 8'hFF) begin
            if (x[22:0] != 23'd0)                      res = x | 32'h0040_0000;
            else if (ey == 8'hFF && x[31] != y[31])    res = 32'h7FC0_0000;
            else                                       res = x;
        end else if (ex == 8'h00) begin
            res = {x[31] & y[31], 31'd0};
        end else if (ey == 8'h00) begin
            res = x;
        end else begin
            // 24-bit significand plus guard, round and sticky bits
            mx  = {1'b1, x[22:0], 3'b000};
            my0 = {1'b1, y[22:0], 3'b000};
            d   = ex - ey;
            if (d > 8'd26) begin
                my = 27'd1;
            end else begin
                my     = my0 >> d;
                sticky = |(my0 & ((27'd1 << d) - 27'd1));
                my[0]  = my[0] | sticky;
            end
            e = int'(ex);
            if (x[31] == y[31]) begin
                s = {1'b0, mx} + {1'b0, my};
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 1;
                end
            end else begin
                s = {1'b0, mx - my};
                // renormalise after cancellation: bring the leading one to bit 26
                for (int i = 0; i < 27; i++) begin
                    if (s[i]) lz = 26 - i;
                end
                s = s << lz;
                e = e - lz;
            end
            if (s == 28'd0) begin
                res = '0;
            end else begin
                rnd = s[2] & (s[1] | s[0] | s[3]);
                rm  = {1'b0, s[26:3]} + {24'd0, rnd};
                if (rm[24]) begin
                    rm = rm >> 1;
                    e  = e + 1;
                end
                if (e >= 255)    res = {x[31], 8'hFF, 23'd0};
                else if (e <= 0) res = {x[31], 31'd0};
                else             res = {x[31], e[7:0], rm[22:0]};
            end
        end
        return res;
    endfunction

    logic [FP_W-1:0] stage_q [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= fp32_add(reg_A, reg_B);
            for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out = stage_q[LAT-1];

endmodule

// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: NUM_REQ requesters share one LAT-cycle FP32 adder.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   en                  : grant enable (in-flight ops still complete when low)
//   req_valid[NUM_REQ]  : per-requester request
//   req_a/req_b         : packed FP32 operands, requester i at [32i+31:32i]
//   req_ready[NUM_REQ]  : one-hot grant
//   rsp_valid[NUM_REQ]  : one-cycle pulse to the owner of a result
//   rsp_data            : FP32 sum, zero when no rsp_valid bit is set
//   busy                : any operation in flight
// Build option: define FPADD_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins, no pointer state).
//
// Handshake: a transfer happens in the cycle where req_valid[i] && req_ready[i].
// req_ready is combinational from req_valid, en and the priority pointer, is
// never raised for a requester that is not valid, and has at most one bit set.
// Responses cannot be stalled: rsp_valid is a pulse the requester must take.
module fpadd_arbiter
    import fpadd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = DEFAULT_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]         rsp_data,
    output logic                    busy
);

    logic               grant_any;
    logic [OWNER_W-1:0] grant_idx;
    logic [FP_W-1:0]    issue_a, issue_b;
    logic [FP_W-1:0]    add_out;
    tag_t               tag_d;
    tag_t               tag_q [LAT];
    tag_t               tag_out;

`ifdef FPADD_ARB_ROUND_ROBIN_EN
    logic [OWNER_W-1:0] ptr_q, ptr_d;
`endif

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
`ifdef FPADD_ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        if (en && !reset) begin
`ifdef FPADD_ARB_ROUND_ROBIN_EN
            // first valid requester at or after the pointer, wrapping around
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                    grant_any = 1'b1;
                    grant_idx = OWNER_W'((int'(ptr_q) + k) % NUM_REQ);
                end
            end
`else
            // descending scan so the lowest asserted index is written last
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[k]) begin
                    grant_any = 1'b1;
                    grant_idx = OWNER_W'(k);
                end
            end
`endif
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_any && (grant_idx == OWNER_W'(i));
        end
`ifdef FPADD_ARB_ROUND_ROBIN_EN
        if (grant_any) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + OWNER_W'(1);
        end
`endif
    end

    // Operand mux: idle cycles feed zeros into the adder.
    always_comb begin
        issue_a = '0;
        issue_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                issue_a = req_a[i*FP_W +: FP_W];
                issue_b = req_b[i*FP_W +: FP_W];
            end
        end
        tag_d.valid = grant_any;
        tag_d.owner = grant_idx;
    end

    // Tag pipeline runs in lockstep with the adder so its last stage names the
    // owner of whatever the adder is presenting this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

`ifdef FPADD_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    fpadd_pipelined #(.LAT(LAT)) u_adder (
        .clk   (clk),
        .reset (reset),
        .reg_A (issue_a),
        .reg_B (issue_b),
        .out   (add_out)
    );

    assign tag_out = tag_q[LAT-1];

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        busy      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag_out.valid && (tag_out.owner == OWNER_W'(i));
        end
        if (tag_out.valid) rsp_data = add_out;
        for (int j = 0; j < LAT; j++) busy = busy | tag_q[j].valid;
    end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter (NUM_REQ=4, LAT=3). Follows the build option
// FPADD_ARB_ROUND_ROBIN_EN for the arbitration policy of its reference model.
module tb_fpadd_arbiter;
    import fpadd_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int W   = 1 + 3 + 32;   // {valid, owner, sum}

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            reset, en;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [32*N-1:0] req_a, req_b;
    logic [31:0]     rsp_data;
    logic            busy;
    int              cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpadd_arbiter #(.NUM_REQ(N), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [31:0]  sums [N];          // hand-computed sum for each requester's operands
    logic [W-1:0] exp_q[$];          // one entry per cycle since reset, oldest first
    int           m_ptr = 0;
    bit           armed = 1'b0;
    int           rsp_count = 0;
    int           last_rsp_cycle = 0;
    int           last_rsp_owner = -1;
    logic [31:0]  last_rsp_data = '0;
    int           gcount [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Arbitration policy: returns winning index, or -1 for no grant.
    function automatic int model_pick(input logic [N-1:0] v, input logic enable,
                                      input logic rst, input int ptr);
        if (!enable || rst) return -1;
`ifdef FPADD_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic         exp_busy;
        logic [N-1:0] exp_rdy, exp_rv;
        logic [31:0]  exp_rd;
        int           g;
        exp_busy = 1'b0;
        foreach (exp_q[k]) exp_busy = exp_busy | exp_q[k][W-1];
        e = '0;
        if (exp_q.size() == LAT) e = exp_q.pop_front();
        exp_rv = '0;
        if (e[W-1]) exp_rv[e[34:32]] = 1'b1;
        exp_rd = e[W-1] ? e[31:0] : 32'h0;
        g = model_pick(req_valid, en, reset, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;

        if (armed) begin
            check("req_ready", req_ready, exp_rdy);
            check("rsp_valid", rsp_valid, exp_rv);
            check("rsp_data",  rsp_data,  exp_rd);
            check("busy",      busy,      exp_busy);
            if (rsp_valid != '0) begin
                rsp_count++;
                last_rsp_cycle = cyc;
                last_rsp_data  = rsp_data;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) last_rsp_owner = i;
            end
            for (int i = 0; i < N; i++) if (req_ready[i]) gcount[i]++;
        end

        if (reset) begin
            exp_q.delete();
            m_ptr = 0;
            armed = 1'b1;
        end else if (g >= 0) begin
            exp_q.push_back({1'b1, 3'(g), sums[g]});
            m_ptr = (g + 1) % N;
        end else begin
            exp_q.push_back('0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] sum);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        sums[i]           = sum;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n0, ic, b0;
        int g0 [N];
        reset     = 1'b1;
        en        = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            sums[i]   = '0;
            gcount[i] = 0;
        end
        tick();
        tick();
        @(negedge clk);
        check("reset_ready_zero", req_ready, 4'b0000);
        check("reset_rsp_valid",  rsp_valid, 4'b0000);
        check("reset_rsp_data",   rsp_data,  32'h0);
        check("reset_busy",       busy,      1'b0);
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = '0;

        // 1.0 + 2.0 on requester 0
        set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        n0 = rsp_count; ic = cyc;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (LAT + 1) tick();
        check("r0_rsp_count",   rsp_count - n0,      1);
        check("r0_rsp_latency", last_rsp_cycle - ic, 3);
        check("r0_rsp_owner",   last_rsp_owner,      0);
        check("r0_rsp_data",    last_rsp_data,       32'h4040_0000);

        // 3.0 + -3.0 on requester 2
        set_op(2, 32'h4040_0000, 32'hC040_0000, 32'h0000_0000);
        n0 = rsp_count; ic = cyc;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (LAT + 1) tick();
        check("r2_rsp_count",   rsp_count - n0,      1);
        check("r2_rsp_latency", last_rsp_cycle - ic, 3);
        check("r2_rsp_owner",   last_rsp_owner,      2);
        check("r2_rsp_data",    last_rsp_data,       32'h0000_0000);

        // all requesters hold valid for 16 cycles, pointer pinned by reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);  // 1 + 2  = 3
        set_op(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);  // 2 + 2  = 4
        set_op(2, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);  // 1 + 1  = 2
        set_op(3, 32'h4080_0000, 32'hBF80_0000, 32'h4040_0000);  // 4 + -1 = 3
        for (int i = 0; i < N; i++) g0[i] = gcount[i];
        n0 = rsp_count;
        req_valid = '1;
        repeat (16) tick();
        req_valid = '0;
`ifdef FPADD_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < N; i++) check($sformatf("rr_grants_%0d", i), gcount[i] - g0[i], 4);
`else
        check("fixed_grants_0", gcount[0] - g0[0], 16);
        for (int i = 1; i < N; i++) check($sformatf("fixed_grants_%0d", i), gcount[i] - g0[i], 0);
`endif
        repeat (LAT + 1) tick();
        check("stream_rsp_count", rsp_count - n0, 16);

        // two ops in flight, then a one-cycle reset discards them
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        reset     = 1'b1;
        n0 = rsp_count;
        tick();
        reset = 1'b0;
        repeat (LAT + 2) tick();
        check("rst_no_rsp",  rsp_count - n0, 0);
        check("rst_busy",    busy,           1'b0);
        req_valid = '1;
        @(negedge clk);
        check("rst_next_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (LAT + 1) tick();

        // grants blocked by en=0 while two ops drain
        b0 = cyc;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1000;
        tick();
        en = 1'b0;
        req_valid = 4'b0101;
        n0 = rsp_count;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("en_low_ready", req_ready, 4'b0000);
            if (cyc == b0 + 4) check("en_low_busy_last", busy, 1'b1);
            if (cyc == b0 + 5) check("en_low_busy_fall", busy, 1'b0);
            @(posedge clk); #1;
        end
        check("en_low_rsp_count", rsp_count - n0,      2);
        check("en_low_last_cyc",  last_rsp_cycle - b0, 4);
        check("en_low_last_own",  last_rsp_owner,      3);
        check("en_low_last_data", last_rsp_data,       32'h4040_0000);
        en = 1'b1;
        repeat (2) tick();
        req_valid = '0;
        repeat (LAT + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
